// File: rtl/preg_free_list_ctrl.sv
// preg_free_list_ctrl: circular FIFO of free physical tags for 2-wide rename, all-or-nothing grant.
// Define FREELIST_DUPCHK_EN to add an in-list bitmap that drops and flags double frees.
module preg_free_list_ctrl #(
    parameter int NUM_PREGS = 64,
    parameter int NUM_AREGS = 32,
    parameter int PTAG_W    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_req_1,
    input  logic              alloc_req_2,
    output logic              alloc_gnt,
    output logic [PTAG_W-1:0] alloc_tag_1,
    output logic [PTAG_W-1:0] alloc_tag_2,
    input  logic              free_valid_1,
    input  logic [PTAG_W-1:0] free_tag_1,
    input  logic              free_valid_2,
    input  logic [PTAG_W-1:0] free_tag_2,
    output logic [PTAG_W:0]   free_count,
    output logic              empty,
    output logic              full,
    output logic              err_overflow,
    output logic              err_bad_tag,
    output logic              err_double_free
);
    localparam int CAP_N = NUM_PREGS - NUM_AREGS;
    localparam logic [PTAG_W:0] CAP = (PTAG_W+1)'(CAP_N);
    logic [PTAG_W-1:0] tags [NUM_PREGS];
    logic [PTAG_W-1:0] head, tail;
    logic [PTAG_W:0] count, take, base;
    logic [1:0] req_n;
    logic dup_1, dup_2, ok_1, ok_2, acc_1, acc_2;
    assign alloc_tag_1 = tags[head];
    assign alloc_tag_2 = alloc_req_1 ? tags[head + PTAG_W'(1)] : tags[head];
    assign free_count = count;
    assign empty = count == '0;
    assign full = count == CAP;
    // Frees see the room left after this cycle's grant; slot 1 claims it first.
    always_comb begin
        req_n = {1'b0, alloc_req_1} + {1'b0, alloc_req_2};
        alloc_gnt = (PTAG_W+1)'(req_n) <= count;
        take = alloc_gnt ? (PTAG_W+1)'(req_n) : '0;
        base = count - take;
        ok_1 = free_valid_1 && free_tag_1 != '0 && !dup_1;
        ok_2 = free_valid_2 && free_tag_2 != '0 && !dup_2;
        acc_1 = ok_1 && base < CAP;
        acc_2 = ok_2 && (base + (PTAG_W+1)'(acc_1)) < CAP;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PREGS; i++)
                tags[i] <= (i < CAP_N) ? PTAG_W'(i + NUM_AREGS) : '0;
            head <= '0;
            tail <= PTAG_W'(CAP_N);
            count <= CAP;
            err_overflow <= 1'b0;
            err_bad_tag <= 1'b0;
        end else begin
            if (acc_1)
                tags[tail] <= free_tag_1;
            if (acc_2)
                tags[tail + PTAG_W'(acc_1)] <= free_tag_2;
            head <= head + PTAG_W'(take);
            tail <= tail + PTAG_W'(acc_1) + PTAG_W'(acc_2);
            count <= base + (PTAG_W+1)'(acc_1) + (PTAG_W+1)'(acc_2);
            err_overflow <= err_overflow | (ok_1 && !acc_1) | (ok_2 && !acc_2);
            err_bad_tag <= err_bad_tag | (free_valid_1 && free_tag_1 == '0) | (free_valid_2 && free_tag_2 == '0);
        end
    end
`ifdef FREELIST_DUPCHK_EN
    logic [NUM_PREGS-1:0] in_list, in_list_nxt;
    assign dup_1 = in_list[free_tag_1];
    assign dup_2 = in_list[free_tag_2] || (free_valid_1 && free_tag_1 == free_tag_2);
    always_comb begin
        in_list_nxt = in_list;
        if (alloc_gnt && alloc_req_1)
            in_list_nxt[alloc_tag_1] = 1'b0;
        if (alloc_gnt && alloc_req_2)
            in_list_nxt[alloc_tag_2] = 1'b0;
        if (acc_1)
            in_list_nxt[free_tag_1] = 1'b1;
        if (acc_2)
            in_list_nxt[free_tag_2] = 1'b1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            in_list <= {{CAP_N{1'b1}}, {NUM_AREGS{1'b0}}};
            err_double_free <= 1'b0;
        end else begin
            in_list <= in_list_nxt;
            err_double_free <= err_double_free | (free_valid_1 && free_tag_1 != '0 && dup_1)
                                               | (free_valid_2 && free_tag_2 != '0 && dup_2);
        end
    end
`else
    assign dup_1 = 1'b0;
    assign dup_2 = 1'b0;
    assign err_double_free = 1'b0;
`endif
endmodule

// File: tb/tb_preg_free_list_ctrl.sv
// tb_preg_free_list_ctrl: directed stimulus against a queue model of the free list.
module tb_preg_free_list_ctrl;
`ifdef FREELIST_DUPCHK_EN
    localparam bit DUP = 1'b1;
`else
    localparam bit DUP = 1'b0;
`endif
    logic clk, rst, alloc_req_1, alloc_req_2, alloc_gnt;
    logic [5:0] alloc_tag_1, alloc_tag_2, free_tag_1, free_tag_2;
    logic free_valid_1, free_valid_2;
    logic [6:0] free_count;
    logic empty, full, err_overflow, err_bad_tag, err_double_free;
    logic [5:0] fl[$];
    logic [5:0] owned[$];
    logic [5:0] t1, t2;
    bit e_ovf, e_bad, e_dbl;
    int passed, total;

    preg_free_list_ctrl dut (
        .clk(clk), .rst(rst),
        .alloc_req_1(alloc_req_1), .alloc_req_2(alloc_req_2),
        .alloc_gnt(alloc_gnt), .alloc_tag_1(alloc_tag_1), .alloc_tag_2(alloc_tag_2),
        .free_valid_1(free_valid_1), .free_tag_1(free_tag_1),
        .free_valid_2(free_valid_2), .free_tag_2(free_tag_2),
        .free_count(free_count), .empty(empty), .full(full),
        .err_overflow(err_overflow), .err_bad_tag(err_bad_tag),
        .err_double_free(err_double_free)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int obs, input int exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
        end
    endtask

    function automatic bit in_fl(input logic [5:0] t);
        foreach (fl[i])
            if (fl[i] == t)
                return 1'b1;
        return 1'b0;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        alloc_req_1 = 1'b1;
        alloc_req_2 = 1'b1;
        free_valid_1 = 1'b1;
        free_tag_1 = 6'd3;
        free_valid_2 = 1'b1;
        free_tag_2 = 6'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        fl.delete();
        owned.delete();
        for (int i = 32; i < 64; i++)
            fl.push_back(6'(i));
        e_ovf = 1'b0;
        e_bad = 1'b0;
        e_dbl = 1'b0;
    endtask

    // Checks pre-edge state and grant, then advances the model across the edge.
    task automatic cycle(input bit r1, input bit r2, input bit v1, input logic [5:0] f1,
                         input bit v2, input logic [5:0] f2);
        int n;
        int k;
        bit g, d1, d2;
        alloc_req_1 = r1;
        alloc_req_2 = r2;
        free_valid_1 = v1;
        free_tag_1 = f1;
        free_valid_2 = v2;
        free_tag_2 = f2;
        n = int'(r1) + int'(r2);
        g = n <= fl.size();
        k = r1 ? 1 : 0;
        @(negedge clk);
        chk("free_count", int'(free_count), fl.size());
        chk("empty", int'(empty), int'(fl.size() == 0));
        chk("full", int'(full), int'(fl.size() == 32));
        chk("err_overflow", int'(err_overflow), int'(e_ovf));
        chk("err_bad_tag", int'(err_bad_tag), int'(e_bad));
        chk("err_double_free", int'(err_double_free), int'(e_dbl));
        chk("alloc_gnt", int'(alloc_gnt), int'(g));
        if (fl.size() > 0)
            chk("alloc_tag_1", int'(alloc_tag_1), int'(fl[0]));
        if (fl.size() > k)
            chk("alloc_tag_2", int'(alloc_tag_2), int'(fl[k]));
        d1 = DUP && in_fl(f1);
        d2 = DUP && (in_fl(f2) || (v1 && f1 == f2));
        if (g)
            repeat (n) owned.push_back(fl.pop_front());
        if (v1) begin
            if (f1 == '0) e_bad = 1'b1;
            else if (d1) e_dbl = 1'b1;
            else if (fl.size() < 32) fl.push_back(f1);
            else e_ovf = 1'b1;
        end
        if (v2) begin
            if (f2 == '0) e_bad = 1'b1;
            else if (d2) e_dbl = 1'b1;
            else if (fl.size() < 32) fl.push_back(f2);
            else e_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        passed = 0;
        total = 0;
        do_reset();
        // drain the list in pairs, then a stalled double request
        repeat (16) cycle(1, 1, 0, '0, 0, '0);
        cycle(1, 1, 0, '0, 0, '0);
        cycle(1, 1, 1, 6'd5, 1, 6'd9);
        cycle(1, 1, 0, '0, 0, '0);
        // alternating free/alloc traffic wraps both pointers
        for (int i = 0; i < 20; i++) begin
            t1 = owned.pop_front();
            t2 = owned.pop_front();
            cycle(0, 0, 1, t1, 1, t2);
            cycle(1, 1, 0, '0, 0, '0);
        end
        t1 = owned.pop_front();
        cycle(0, 0, 1, t1, 0, '0);
        t1 = owned.pop_front();
        t2 = owned.pop_front();
        cycle(1, 0, 1, t1, 1, t2);
        t1 = owned.pop_front();
        cycle(0, 1, 0, '0, 1, t1);
        while (fl.size() < 32) begin
            t1 = owned.pop_front();
            if (fl.size() < 31) begin
                t2 = owned.pop_front();
                cycle(0, 0, 1, t1, 1, t2);
            end else begin
                cycle(0, 0, 1, t1, 0, '0);
            end
        end
        // overflow and bad-tag at full, including alloc-then-free room
        cycle(1, 0, 1, 6'd7, 1, 6'd8);
        cycle(0, 0, 1, 6'd8, 0, '0);
        cycle(0, 0, 0, '0, 1, 6'd0);
        cycle(0, 0, 0, '0, 0, '0);
        do_reset();
        cycle(0, 1, 0, '0, 0, '0);
        cycle(1, 0, 0, '0, 0, '0);
        // duplicate frees
        repeat (15) cycle(1, 1, 0, '0, 0, '0);
        cycle(0, 0, 1, 6'd32, 0, '0);
        cycle(0, 0, 1, 6'd32, 0, '0);
        cycle(0, 0, 1, 6'd40, 1, 6'd40);
        cycle(0, 0, 0, '0, 0, '0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/preg_free_list_ctrl.md
Name: preg_free_list_ctrl

Overview:
- Manages the pool of unallocated physical registers for the 2-wide rename stage.
- Hands out up to two destination tags per cycle to rename and reclaims up to two old-mapping tags per cycle from retire (fp_ind_1/fp_ind_2).
- Implemented as a circular FIFO of tags with all-or-nothing allocation grant.
- Sits between the rename stage (consumer) and the complete/retire stage (producer of freed tags).

Parameters:
NUM_PREGS, 64, number of physical registers; power of two.
NUM_AREGS, 32, number of architectural registers; p0..p(NUM_AREGS-1) are mapped at reset.
PTAG_W, 6, physical tag width, equal to log2(NUM_PREGS).

Ports:
clk  input  1  system clock; all state updates on posedge.
rst  input  1  synchronous reset, active-high.
alloc_req_1  input  1  rename slot 1 needs a destination tag.
alloc_req_2  input  1  rename slot 2 needs a destination tag.
alloc_gnt  output  1  all requested tags are available this cycle.
alloc_tag_1  output  PTAG_W  tag for slot 1.
alloc_tag_2  output  PTAG_W  tag for slot 2.
free_valid_1  input  1  retire returns free_tag_1.
free_tag_1  input  PTAG_W  tag being released.
free_valid_2  input  1  retire returns free_tag_2.
free_tag_2  input  PTAG_W  tag being released.
free_count  output  PTAG_W+1  number of tags currently in the list.
empty  output  1  free_count == 0.
full  output  1  free_count == NUM_PREGS-NUM_AREGS.
err_overflow  output  1  sticky: a free was dropped because the list was full.
err_bad_tag  output  1  sticky: a free of tag 0 was dropped.

Behaviour:
- Storage: NUM_PREGS-entry tag array, head and tail pointers of PTAG_W bits (wrap modulo NUM_PREGS), counter of PTAG_W+1 bits.
- Capacity: NUM_PREGS-NUM_AREGS.
- Reset (synchronous): array entries 0..31 = tags 32..63; head=0; tail=32; free_count=32; full=1; empty=0; err flags=0. Reset overrides any same-cycle request or free.
- Peek is combinational from head:
  - alloc_tag_1 = array[head].
  - alloc_tag_2 = array[head+1] if alloc_req_1, else array[head] (slot compaction).
- req_n = alloc_req_1 + alloc_req_2. alloc_gnt = (req_n <= free_count), combinational.
- req_n == 0 gives alloc_gnt=1 with no state change.
- Allocation latency is 0. On posedge with alloc_gnt and req_n>0: head += req_n, count -= req_n.
- No partial grants. If only 1 tag is free and both slots request, alloc_gnt=0 and nothing is consumed. Rename must stall and hold its requests.
- Free handling, at posedge:
  - Each valid free with tag!=0 is written at tail; slot 1 before slot 2, compacted if only slot 2 is valid. tail += number written, count += number written.
  - A free of tag 0 is dropped and sets err_bad_tag.
- Overflow: if accepting a free would exceed capacity (counting the same-cycle allocation first), that free is dropped and sets err_overflow. Slot 1 has priority over slot 2.
- Simultaneous alloc and free: alloc_gnt is evaluated against the pre-edge free_count only. Freed tags become allocatable on the following cycle (1-cycle free-to-alloc latency). Net count = count - granted + accepted frees.
- Error flags clear only on rst.
- Reset mid-operation: all in-flight allocations are forgotten and the list returns to the reset image. The rename table is reset by its owner in the same cycle.

Optional Feature:
Macro FREELIST_DUPCHK_EN.
- Defined: keep a NUM_PREGS-bit in_list bitmap.
  - Reset value: bits 32..63 set.
  - Set on accepted free; cleared on grant.
  - A free of a tag whose bit is already set is dropped and sets an extra sticky output err_double_free.
  - Two same-cycle frees of the same tag: slot 1 is accepted, slot 2 is flagged.
- Undefined: no bitmap, duplicate frees are accepted silently, and err_double_free is tied to 0.

Test Plan:
1. Assert rst for 1 cycle -> free_count=32, full=1, alloc_tag_1=32, alloc_tag_2=33, errors 0.
2. Hold alloc_req_1=alloc_req_2=1 for 16 cycles -> granted tags 32..63 in order; then empty=1, free_count=0; on the 17th cycle alloc_gnt=0 and head is unchanged.
3. From empty, same cycle: both alloc_req, free 5 and 9 -> alloc_gnt=0; next cycle free_count=2, alloc_tag_1=5, alloc_tag_2=9, alloc_gnt=1.
4. Drive 40 cycles of alternating 2-alloc / 2-free traffic so the pointers wrap past 63 -> FIFO order is preserved across the wrap; free_count never exceeds 32.
5. At full, free tag 7, then free tag 0 -> err_overflow=1, err_bad_tag=1, free_count stays 32; then rst clears both flags.
6. With FREELIST_DUPCHK_EN: allocate 32, free 32, then free 32 again -> second free dropped, err_double_free=1, free_count=1.
